handshake_fifo: RTL and testbench

Elastic buffer that sits directly downstream of an `arf` output port (`dout_req_N`/`dout_ack_N`/`dout_N`) and upstream of a `consumer`. It absorbs consumer stalls by pulling words from the dataflow graph whenever it has room. It then serves them to the consumer in order, using the same pulse-ack req/ack protocol on both sides. The block decouples graph throughput from consumer `fail_rate` during throughput simulations.

---
 rtl/handshake_fifo.sv | 88 ++++++++
 tb/tb_handshake_fifo.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/handshake_fifo.sv
// Elastic req/ack buffer between a dataflow output port and a consumer.
// Pulls words while space remains and serves them in order with one-cycle ack pulses.
module handshake_fifo #(
    parameter int data_width = 32,
    parameter int depth      = 4,
    parameter int addr_width = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  req_l,
    input  logic                  ack_l,
    input  logic [data_width-1:0] din,
    input  logic                  req_r,
    output logic                  ack_r,
    output logic [data_width-1:0] dout,
    output logic [addr_width:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow
);

    localparam logic [addr_width:0] depth_l = (addr_width + 1)'(depth);

    logic [data_width-1:0] mem [depth];
    logic [addr_width-1:0] wp;
    logic [addr_width-1:0] rp;
    logic                  ack_l_q;
    logic                  push;
    logic                  pop;
    logic                  write_en;
    logic                  drop;
    logic [addr_width:0]   level_next;

    assign empty = (level == '0);
    assign full  = (level == depth_l);

    assign push = ack_l & ~ack_l_q;
    assign pop  = req_r & ~ack_r & ~empty;
    // A push into a full buffer is only accepted if a pop frees a slot on the same edge.
    assign write_en = push & (~full | pop);
    assign drop     = push & full & ~pop;

    always_comb begin
        level_next = level;
        case ({write_en, pop})
            2'b10:   level_next = level + (addr_width + 1)'(1);
            2'b01:   level_next = level - (addr_width + 1)'(1);
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[wp] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            level    <= '0;
            ack_l_q  <= 1'b0;
            req_l    <= 1'b0;
            ack_r    <= 1'b0;
            dout     <= '0;
            overflow <= 1'b0;
        end else begin
            ack_l_q <= ack_l;
            level   <= level_next;
            req_l   <= (level_next < depth_l);
            if (write_en) begin
                wp <= wp + addr_width'(1);
            end
            if (pop) begin
                ack_r <= 1'b1;
                dout  <= mem[rp];
                rp    <= rp + addr_width'(1);
            end else begin
                ack_r <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_handshake_fifo.sv
// Directed vector table plus a long randomised producer/consumer stream for handshake_fifo.
module tb_handshake_fifo;

    logic        clk;
    logic        rst;
    logic        req_l;
    logic        ack_l;
    logic [31:0] din;
    logic        req_r;
    logic        ack_r;
    logic [31:0] dout;
    logic [2:0]  level;
    logic        empty;
    logic        full;
    logic        overflow;

    int checks;
    int errors;

    handshake_fifo #(.data_width(32), .depth(4)) dut (
        .clk(clk), .rst(rst), .req_l(req_l), .ack_l(ack_l), .din(din),
        .req_r(req_r), .ack_r(ack_r), .dout(dout), .level(level),
        .empty(empty), .full(full), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ack_l;
        logic [31:0] din;
        logic        req_r;
        logic        ack_r;
        logic [31:0] dout;
        logic [2:0]  level;
        logic        req_l;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic r, input logic a, input int d, input logic q,
                     input logic e_ack, input int e_dout, input int e_lvl,
                     input logic e_req, input logic e_ovf);
        vec_t t;
        t.rst = r; t.ack_l = a; t.din = d; t.req_r = q;
        t.ack_r = e_ack; t.dout = e_dout; t.level = 3'(e_lvl);
        t.req_l = e_req; t.ovf = e_ovf;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    int exp_rx;
    int sent;
    int both_seen;
    int prev_level;
    logic pushed;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; ack_l = 1'b0; din = '0; req_r = 1'b1;

        // rst ack din req | ack_r dout level req_l ovf
        v(1,0, 0,1, 0,0,0,0,0);  v(1,0, 0,1, 0,0,0,0,0);
        v(0,0, 0,1, 0,0,0,1,0);  v(0,0, 0,1, 0,0,0,1,0);
        v(0,1, 7,1, 0,0,1,1,0);  v(0,0, 0,1, 1,7,0,1,0);  v(0,0, 0,1, 0,7,0,1,0);
        v(0,1, 0,0, 0,7,1,1,0);  v(0,0, 0,0, 0,7,1,1,0);
        v(0,1, 1,0, 0,7,2,1,0);  v(0,1, 1,0, 0,7,2,1,0);  v(0,0, 0,0, 0,7,2,1,0);
        v(0,1, 2,0, 0,7,3,1,0);  v(0,0, 0,0, 0,7,3,1,0);
        v(0,1, 3,0, 0,7,4,0,0);  v(0,0, 0,0, 0,7,4,0,0);
        v(0,1,99,0, 0,7,4,0,1);  v(0,0, 0,0, 0,7,4,0,1);
        v(0,0, 0,1, 1,0,3,1,1);  v(0,0, 0,1, 0,0,3,1,1);
        v(0,0, 0,1, 1,1,2,1,1);  v(0,0, 0,1, 0,1,2,1,1);
        v(0,0, 0,1, 1,2,1,1,1);  v(0,0, 0,1, 0,2,1,1,1);
        v(0,0, 0,1, 1,3,0,1,1);  v(0,0, 0,1, 0,3,0,1,1);  v(0,0, 0,1, 0,3,0,1,1);
        v(1,0, 0,0, 0,0,0,0,0);  v(0,0, 0,0, 0,0,0,1,0);
        v(0,1,11,0, 0,0,1,1,0);  v(0,0, 0,0, 0,0,1,1,0);
        v(0,1,12,0, 0,0,2,1,0);  v(0,0, 0,0, 0,0,2,1,0);
        v(0,1,13,0, 0,0,3,1,0);  v(0,0, 0,0, 0,0,3,1,0);
        v(1,0, 0,1, 0,0,0,0,0);  v(0,0, 0,1, 0,0,0,1,0);  v(0,0, 0,1, 0,0,0,1,0);
        v(0,1,20,0, 0,0,1,1,0);  v(0,0, 0,0, 0,0,1,1,0);
        v(0,1,21,0, 0,0,2,1,0);  v(0,0, 0,0, 0,0,2,1,0);
        v(0,1,22,0, 0,0,3,1,0);  v(0,0, 0,0, 0,0,3,1,0);
        v(0,1,23,0, 0,0,4,0,0);  v(0,0, 0,0, 0,0,4,0,0);
        // full, push and pop on the same edge; 24 lands in the slot 20 leaves
        v(0,1,24,1, 1,20,4,0,0); v(0,0, 0,1, 0,20,4,0,0);
        v(0,0, 0,1, 1,21,3,1,0); v(0,0, 0,1, 0,21,3,1,0);
        v(0,0, 0,1, 1,22,2,1,0); v(0,0, 0,1, 0,22,2,1,0);
        v(0,0, 0,1, 1,23,1,1,0); v(0,0, 0,1, 0,23,1,1,0);
        v(0,0, 0,1, 1,24,0,1,0); v(0,0, 0,1, 0,24,0,1,0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; ack_l = vecs[i].ack_l; din = vecs[i].din; req_r = vecs[i].req_r;
            @(posedge clk);
            #1;
            check($sformatf("v%0d ack_r", i), ack_r, vecs[i].ack_r);
            check($sformatf("v%0d dout", i), dout, vecs[i].dout);
            check($sformatf("v%0d level", i), level, vecs[i].level);
            check($sformatf("v%0d req_l", i), req_l, vecs[i].req_l);
            check($sformatf("v%0d overflow", i), overflow, vecs[i].ovf);
            check($sformatf("v%0d empty", i), empty, vecs[i].level == 0);
            check($sformatf("v%0d full", i), full, vecs[i].level == 4);
        end

        // Stream: pulse producer honouring req_l, consumer stalling ~30% of cycles.
        exp_rx = 0;
        sent = 0;
        both_seen = 0;
        ack_l = 1'b0;
        din = '0;
        req_r = 1'b1;
        for (int cyc = 0; cyc < 60000 && exp_rx < 5000; cyc++) begin
            prev_level = level;
            pushed = ack_l;
            @(posedge clk);
            #1;
            if (ack_r) begin
                check("stream dout", dout, exp_rx);
                exp_rx++;
                if (pushed && level == prev_level) both_seen++;
            end
            if (level > 4) check("stream level bound", level, 4);
            if (overflow) check("stream overflow", overflow, 0);
            if (ack_l) begin
                ack_l = 1'b0;
            end else if (req_l && sent < 5000) begin
                ack_l = 1'b1;
                din = sent;
                sent++;
            end
            req_r = ($urandom_range(0, 99) >= 30);
        end
        check("stream words received", exp_rx, 5000);
        check("stream final overflow", overflow, 0);
        check("stream push+pop same edge seen", both_seen > 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
